// File: rtl/sfp_div_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
// The producer of operands and consumer of results uses master; the divider uses slave.
interface sfp_div_seq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         clipping;

   modport master (
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, out, clipping
   );

   modport slave (
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, out, clipping
   );
endinterface

// File: rtl/sfp_div_seq.sv
// Sequential signed Q(IW.QW) divider: non-restoring magnitude division,
// one quotient bit per cycle, truncation toward zero, saturate or wrap on overflow.
module sfp_div_seq #(
   parameter int IW   = 16,
   parameter int QW   = 16,
   parameter int CLIP = 1
) (
   input logic         clk,
   input logic         rst_n,
   sfp_div_seq_if.slave bus
);
   localparam int W  = IW + QW;
   localparam int N  = W + QW;
   localparam int RW = W + 2;
   localparam int CW = $clog2(N);

   localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
   localparam logic [N-1:0] LIM_P = {{QW{1'b0}}, 1'b0, {(W-1){1'b1}}};
   localparam logic [N-1:0] LIM_N = {{QW{1'b0}}, 1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nx;
   logic                sign;
   logic [W-1:0]        dv;
   logic [N-1:0]        dq;
   logic signed [RW-1:0] rem;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        out_q;
   logic                clip_q;

   logic                accept, last, y_zero;
   logic [W-1:0]        ax, ay;
   logic signed [RW-1:0] rem_sh, rem_nx, dv_s;
   logic [N-1:0]        dq_nx;
   logic [W-1:0]        q_lo, res, fin;
   logic                ovf;

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (cnt == CW'(N-1));
   assign y_zero = (bus.y == '0);

   // two's-complement negate of the most negative value stays 2^(W-1), which is the exact magnitude
   assign ax = bus.x[W-1] ? -bus.x : bus.x;
   assign ay = bus.y[W-1] ? -bus.y : bus.y;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out       = out_q;
   assign bus.clipping  = clip_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = y_zero ? DONE : CALC;
         CALC:    if (last) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // dq shifts dividend bits out of the top while quotient bits enter at the bottom
   always_comb begin
      dv_s   = $signed({2'b00, dv});
      rem_sh = {rem[RW-2:0], dq[N-1]};
      rem_nx = rem[RW-1] ? (rem_sh + dv_s) : (rem_sh - dv_s);
      dq_nx  = {dq[N-2:0], ~rem_nx[RW-1]};
      q_lo   = dq_nx[W-1:0];
      ovf    = sign ? (dq_nx > LIM_N) : (dq_nx > LIM_P);
      res    = sign ? -q_lo : q_lo;
      fin    = (ovf && CLIP != 0) ? (sign ? MIN_V : MAX_V) : res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign   <= 1'b0;
         dv     <= '0;
         dq     <= '0;
         rem    <= '0;
         cnt    <= '0;
         out_q  <= '0;
         clip_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign <= bus.x[W-1] ^ bus.y[W-1];
               dv   <= ay;
               dq   <= {ax, {QW{1'b0}}};
               rem  <= '0;
               cnt  <= '0;
               if (y_zero) begin
                  out_q  <= bus.x[W-1] ? MIN_V : MAX_V;
                  clip_q <= 1'b1;
               end
            end
            CALC: begin
               rem <= rem_nx;
               dq  <= dq_nx;
               cnt <= last ? '0 : cnt + CW'(1);
               if (last) begin
                  out_q  <= fin;
                  clip_q <= ovf;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sfp_div_seq.sv
// Randomized + directed bench for sfp_div_seq; a saturating and a wrapping instance
// run in lockstep against an arithmetic reference model.
module tb_sfp_div_seq;
   localparam int W = 32;
   localparam logic [31:0] MAXV = 32'h7FFFFFFF;
   localparam logic [31:0] MINV = 32'h80000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sfp_div_seq_if #(.W(W)) b1 ();
   sfp_div_seq_if #(.W(W)) b0 ();

   sfp_div_seq #(.IW(16), .QW(16), .CLIP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   sfp_div_seq #(.IW(16), .QW(16), .CLIP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // exact rational quotient truncated toward zero, then range check
   function automatic void model(input logic [31:0] a, input logic [31:0] bb, input bit clip,
                                 output logic [31:0] q, output logic c);
      longint sa, sb, ma, mb, qq, r;
      if (bb == 32'h0) begin
         q = a[31] ? MINV : MAXV;
         c = 1'b1;
         return;
      end
      sa = longint'($signed(a));
      sb = longint'($signed(bb));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      qq = (ma * 65536) / mb;
      r  = ((sa < 0) != (sb < 0)) ? -qq : qq;
      c  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      if (c && clip) q = (r < 0) ? MINV : MAXV;
      else           q = r[31:0];
   endfunction

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] bb, input logic r);
      b1.in_valid = v; b1.x = a; b1.y = bb; b1.out_ready = r;
      b0.in_valid = v; b0.x = a; b0.y = bb; b0.out_ready = r;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] bb, input int hold,
                         input bit has_exp, input logic [31:0] exp1);
      logic [31:0] e1, e0;
      logic        c1, c0;
      int          lat;
      model(a, bb, 1'b1, e1, c1);
      model(a, bb, 1'b0, e0, c0);
      chk("idle_in_ready", {b1.in_ready, b0.in_ready}, 2'b11);
      drive(1'b1, a, bb, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, $urandom, $urandom, 1'b0);
      lat = 1;
      while (!b1.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, (bb == 32'h0) ? 1 : 49);
      chk("valid_wrap", b0.out_valid, 1'b1);
      chk("out_sat", b1.out, e1);
      chk("clip_sat", b1.clipping, c1);
      chk("out_wrap", b0.out, e0);
      chk("clip_wrap", b0.clipping, c0);
      if (has_exp) chk("out_ref", b1.out, exp1);
      for (int i = 0; i < hold; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
         @(posedge clk); #1;
         chk("hold_valid", {b1.out_valid, b0.out_valid}, 2'b11);
         chk("hold_in_ready", {b1.in_ready, b0.in_ready}, 2'b00);
         chk("hold_out", {b1.out, b0.out}, {e1, e0});
         chk("hold_clip", {b1.clipping, b0.clipping}, {c1, c0});
      end
      // operands offered in the take cycle must not be accepted
      drive(1'b1, 32'h00010000, 32'h00010000, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      chk("taken_valid", {b1.out_valid, b0.out_valid}, 2'b00);
      chk("no_accept", {b1.in_ready, b0.in_ready}, 2'b11);
      chk("keep_out", {b1.out, b0.out}, {e1, e0});
   endtask

   logic [31:0] tv [10][3] = '{
      '{32'h00060000, 32'h00020000, 32'h00030000},
      '{32'hFFFF0000, 32'h00040000, 32'hFFFFC000},
      '{32'h00010000, 32'h00030000, 32'h00005555},
      '{32'h7FFF0000, 32'h00000100, 32'h7FFFFFFF},
      '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF},
      '{32'hFFFF0000, 32'h00000000, 32'h80000000},
      '{32'h00000000, 32'h00000000, 32'h7FFFFFFF},
      '{32'h80000000, 32'h00010000, 32'h80000000},
      '{32'hFFFFFFFF, 32'h00020000, 32'h00000000},
      '{32'h80000000, 32'h80000000, 32'h00010000}
   };

   initial begin
      logic [31:0] a, bb;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {b1.in_ready, b0.in_ready}, 2'b11);
      chk("rst_out_valid", {b1.out_valid, b0.out_valid}, 2'b00);
      chk("rst_out", {b1.out, b0.out}, 64'h0);
      chk("rst_clip", {b1.clipping, b0.clipping}, 2'b00);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(tv[i][0], tv[i][1], (i == 0) ? 10 : 1, 1'b1, tv[i][2]);

      // abort mid-calculation; the pending result must vanish
      drive(1'b1, 32'h00070000, 32'h00020000, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {b1.in_ready, b0.in_ready}, 2'b11);
      chk("abort_out_valid", {b1.out_valid, b0.out_valid}, 2'b00);
      chk("abort_out", {b1.out, b0.out}, 64'h0);
      chk("abort_clip", {b1.clipping, b0.clipping}, 2'b00);
      @(posedge clk); #1 rst_n = 1'b1;
      run_op(32'h00060000, 32'h00020000, 2, 1'b1, 32'h00030000);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       bb = 32'h0;
            1:       bb = 32'($urandom_range(1, 255));
            2:       bb = $urandom;
            default: bb = $urandom & 32'h000FFFFF;
         endcase
         if ($urandom_range(0, 1) == 1) bb = -bb;
         if (i % 7 == 3) a = MINV;
         run_op(a, bb, $urandom_range(0, 3), 1'b0, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
